// File: rtl/tick_watchdog_if.sv
// tick_watchdog_if
//   Bundles the control inputs and status outputs of the tick watchdog.
//   clk and reset are not part of the bundle; they stay plain module ports.
//
//   master modport (software/prescaler side):
//     drives  tick, enable, kick, clear_expired, warn_ticks, timeout_ticks
//     reads   tick_count, warn, expired, bite, state
//   slave modport (the watchdog itself):
//     the same signals with the directions reversed
interface tick_watchdog_if #(
    parameter int CNT_W = 16
);
    logic             tick;
    logic             enable;
    logic             kick;
    logic             clear_expired;
    logic [CNT_W-1:0] warn_ticks;
    logic [CNT_W-1:0] timeout_ticks;
    logic [CNT_W-1:0] tick_count;
    logic             warn;
    logic             expired;
    logic             bite;
    logic [1:0]       state;

    modport master (
        output tick, enable, kick, clear_expired, warn_ticks, timeout_ticks,
        input  tick_count, warn, expired, bite, state
    );

    modport slave (
        input  tick, enable, kick, clear_expired, warn_ticks, timeout_ticks,
        output tick_count, warn, expired, bite, state
    );
endinterface

// File: rtl/tick_watchdog.sv
// tick_watchdog
//   Counts rising edges of the prescaler terminal-count pulse and runs a
//   watchdog through IDLE -> ARMED -> WARN -> EXPIRED. Software can kick
//   (restart the count), disarm (enable low) and clear an expiry.
//
//   Ports:
//     clk    system clock, all logic on the rising edge
//     reset  synchronous, active-high reset
//     wd     tick_watchdog_if.slave
//              inputs : tick, enable, kick, clear_expired,
//                       warn_ticks, timeout_ticks
//              outputs: tick_count, warn, expired, bite, state
//                       (all registered)
module tick_watchdog #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    tick_watchdog_if.slave wd
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_WARN    = 2'b10,
        ST_EXPIRED = 2'b11
    } state_e;

    state_e           state_q,       state_d;
    logic [CNT_W-1:0] count_q,       count_d;
    logic [CNT_W-1:0] warn_lat_q,    warn_lat_d;
    logic [CNT_W-1:0] timeout_lat_q, timeout_lat_d;
    logic             tick_q,        tick_d;
    logic             warn_q,        warn_d;
    logic             expired_q,     expired_d;
    logic             bite_q,        bite_d;

    logic             tick_event;
    logic [CNT_W-1:0] count_inc;
    logic             warn_phase_en;

    // A tick held high for several cycles must count only once, so only
    // the low-to-high transition is an event.
    assign tick_event = wd.tick & ~tick_q;
    assign count_inc  = count_q + 1'b1;

    // The WARN phase only exists when the latched warn point lies strictly
    // between zero and the timeout; otherwise ARMED goes straight to EXPIRED.
    assign warn_phase_en = (warn_lat_q != '0) && (warn_lat_q < timeout_lat_q);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        count_d       = count_q;
        warn_lat_d    = warn_lat_q;
        timeout_lat_d = timeout_lat_q;
        tick_d        = wd.tick;

        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                // Arming with a zero timeout is refused; thresholds are
                // captured only on the arming edge.
                if (wd.enable && (wd.timeout_ticks != '0)) begin
                    state_d       = ST_ARMED;
                    warn_lat_d    = wd.warn_ticks;
                    timeout_lat_d = wd.timeout_ticks;
                end
            end

            ST_ARMED, ST_WARN: begin
                // Priority: disarm > kick > tick event. A kick in the same
                // cycle as an event drops the event.
                if (!wd.enable) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (wd.kick) begin
                    state_d = ST_ARMED;
                    count_d = '0;
                end else if (tick_event) begin
                    count_d = count_inc;
                    if (count_inc == timeout_lat_q) begin
                        state_d = ST_EXPIRED;
                    end else if ((state_q == ST_ARMED) && warn_phase_en &&
                                 (count_inc == warn_lat_q)) begin
                        state_d = ST_WARN;
                    end
                end
            end

            ST_EXPIRED: begin
                // Count stays frozen at the timeout; only clear leaves here.
                if (wd.clear_expired) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        // Status flags are registered copies of the next state, so they line
        // up with the state output. bite marks only the entry into EXPIRED.
        warn_d    = (state_d == ST_WARN);
        expired_d = (state_d == ST_EXPIRED);
        bite_d    = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            warn_lat_q    <= '0;
            timeout_lat_q <= '0;
            tick_q        <= 1'b0;
            warn_q        <= 1'b0;
            expired_q     <= 1'b0;
            bite_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            warn_lat_q    <= warn_lat_d;
            timeout_lat_q <= timeout_lat_d;
            tick_q        <= tick_d;
            warn_q        <= warn_d;
            expired_q     <= expired_d;
            bite_q        <= bite_d;
        end
    end

    assign wd.tick_count = count_q;
    assign wd.warn       = warn_q;
    assign wd.expired    = expired_q;
    assign wd.bite       = bite_q;
    assign wd.state      = state_q;

endmodule
